// File: rtl/pulse_channel_gen.sv
// Square-wave APU channel: envelope, sweep, timer, 8-step duty sequencer and length counter.
// Define PULSE_SWEEP_EN to build the sweep unit; without it the period changes only via register writes.
module pulse_channel_gen #(
  parameter int TIMER_W  = 11,
  parameter int NEG_ONES = 0,
  parameter int MIN_PER  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       apu_clk,
  input  logic       half_frame,
  input  logic       quarter_frame,
  input  logic [3:0] op,
  input  logic [7:0] wdata,
  input  logic       enable,
  output logic       length_status,
  output logic [3:0] wave,
  output logic [3:0] volume
);

  localparam logic [TIMER_W-1:0] MIN_PER_W = TIMER_W'(MIN_PER);
  // Step 0 is the leftmost bit of each pattern.
  localparam logic [3:0][7:0] DUTY_PAT = {8'b10011111, 8'b01111000, 8'b01100000, 8'b01000000};

  logic [7:0]         ctrl_reg;
  logic [TIMER_W-1:0] period_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [2:0]         seq_step_reg;
  logic [7:0]         length_reg;
  logic               env_start_reg;
  logic [3:0]         env_div_reg;
  logic [3:0]         env_decay_reg;

  logic               mute;
  logic               sweep_fire;
  logic [TIMER_W-1:0] sweep_period;
  logic               cpu_op_ctrl;
  logic               cpu_op_lo;
  logic               cpu_op_hi;

  assign cpu_op_ctrl = cpu_en & op[0];
  assign cpu_op_lo   = cpu_en & op[2];
  assign cpu_op_hi   = cpu_en & op[3];

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    case (idx)
      5'd0:  len_lookup = 8'd10;
      5'd1:  len_lookup = 8'd254;
      5'd2:  len_lookup = 8'd20;
      5'd3:  len_lookup = 8'd2;
      5'd4:  len_lookup = 8'd40;
      5'd5:  len_lookup = 8'd4;
      5'd6:  len_lookup = 8'd80;
      5'd7:  len_lookup = 8'd6;
      5'd8:  len_lookup = 8'd160;
      5'd9:  len_lookup = 8'd8;
      5'd10: len_lookup = 8'd60;
      5'd11: len_lookup = 8'd10;
      5'd12: len_lookup = 8'd14;
      5'd13: len_lookup = 8'd12;
      5'd14: len_lookup = 8'd26;
      5'd15: len_lookup = 8'd14;
      5'd16: len_lookup = 8'd12;
      5'd17: len_lookup = 8'd16;
      5'd18: len_lookup = 8'd24;
      5'd19: len_lookup = 8'd18;
      5'd20: len_lookup = 8'd48;
      5'd21: len_lookup = 8'd20;
      5'd22: len_lookup = 8'd96;
      5'd23: len_lookup = 8'd22;
      5'd24: len_lookup = 8'd192;
      5'd25: len_lookup = 8'd24;
      5'd26: len_lookup = 8'd72;
      5'd27: len_lookup = 8'd26;
      5'd28: len_lookup = 8'd16;
      5'd29: len_lookup = 8'd28;
      5'd30: len_lookup = 8'd32;
      default: len_lookup = 8'd30;
    endcase
  endfunction

`ifdef PULSE_SWEEP_EN
  localparam logic [TIMER_W:0] NEG_ADJ = (TIMER_W+1)'(NEG_ONES != 0);

  logic [7:0]       sweep_reg;
  logic [2:0]       sdiv_reg;
  logic             sreload_reg;
  logic [TIMER_W:0] sweep_delta;
  logic [TIMER_W:0] sweep_target;

  assign sweep_delta  = {1'b0, period_reg} >> sweep_reg[2:0];
  assign sweep_target = sweep_reg[3] ? ({1'b0, period_reg} - sweep_delta - NEG_ADJ)
                                     : ({1'b0, period_reg} + sweep_delta);
  assign mute         = (period_reg < MIN_PER_W) | (~sweep_reg[3] & sweep_target[TIMER_W]);
  assign sweep_fire   = cpu_en & half_frame & (sdiv_reg == 3'd0) & sweep_reg[7]
                      & (sweep_reg[2:0] != 3'd0) & ~mute;
  assign sweep_period = sweep_target[TIMER_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_reg   <= '0;
      sdiv_reg    <= '0;
      sreload_reg <= 1'b0;
    end else if (cpu_en) begin
      if (half_frame) begin
        if (sdiv_reg == 3'd0 || sreload_reg) begin
          sdiv_reg    <= sweep_reg[6:4];
          sreload_reg <= 1'b0;
        end else begin
          sdiv_reg <= sdiv_reg - 3'd1;
        end
      end
      if (op[1]) begin
        sweep_reg   <= wdata;
        sreload_reg <= 1'b1;
      end
    end
  end
`else
  logic unused_sweep_op;
  assign unused_sweep_op = op[1];
  assign mute            = period_reg < MIN_PER_W;
  assign sweep_fire      = 1'b0;
  assign sweep_period    = period_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg      <= '0;
      period_reg    <= '0;
      timer_reg     <= '0;
      seq_step_reg  <= '0;
      length_reg    <= '0;
      env_start_reg <= 1'b0;
      env_div_reg   <= '0;
      env_decay_reg <= '0;
    end else if (cpu_en) begin
      if (cpu_op_ctrl) ctrl_reg <= wdata;

      // Register writes take priority over a sweep update in the same cycle.
      if (cpu_op_lo || cpu_op_hi) begin
        if (cpu_op_lo) period_reg[7:0] <= wdata;
        if (cpu_op_hi) period_reg[TIMER_W-1:8] <= wdata[TIMER_W-9:0];
      end else if (sweep_fire) begin
        period_reg <= sweep_period;
      end

      if (apu_clk) begin
        if (timer_reg == '0) begin
          timer_reg    <= period_reg;
          seq_step_reg <= seq_step_reg + 3'd1;
        end else begin
          timer_reg <= timer_reg - 1'b1;
        end
      end
      if (cpu_op_hi) seq_step_reg <= 3'd0;

      if (quarter_frame) begin
        if (env_start_reg) begin
          env_start_reg <= 1'b0;
          env_decay_reg <= 4'd15;
          env_div_reg   <= ctrl_reg[3:0];
        end else if (env_div_reg == 4'd0) begin
          env_div_reg <= ctrl_reg[3:0];
          if (env_decay_reg != 4'd0) env_decay_reg <= env_decay_reg - 4'd1;
          else if (ctrl_reg[5])      env_decay_reg <= 4'd15;
        end else begin
          env_div_reg <= env_div_reg - 4'd1;
        end
      end
      if (cpu_op_hi) env_start_reg <= 1'b1;

      if (!enable)
        length_reg <= 8'd0;
      else if (cpu_op_hi)
        length_reg <= len_lookup(wdata[7:3]);
      else if (half_frame && length_reg != 8'd0 && !ctrl_reg[5])
        length_reg <= length_reg - 8'd1;
    end
  end

  logic [3:0] duty_hits;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_duty
      assign duty_hits[gi] = DUTY_PAT[gi][3'd7 - seq_step_reg];
    end
  endgenerate

  logic [3:0] env_volume;
  assign env_volume    = ctrl_reg[4] ? ctrl_reg[3:0] : env_decay_reg;
  assign length_status = length_reg != 8'd0;
  assign volume        = (length_status && !mute) ? env_volume : 4'd0;
  assign wave          = duty_hits[ctrl_reg[7:6]] ? volume : 4'd0;

endmodule

// File: tb/tb_pulse_channel_gen.sv
// Directed bench for pulse_channel_gen: tone timing, reset, length table, envelope, mute and sweep.
module tb_pulse_channel_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_en = 1'b1;
  logic       apu_clk = 1'b0;
  logic       half_frame = 1'b0;
  logic       quarter_frame = 1'b0;
  logic [3:0] op = 4'd0;
  logic [7:0] wdata = 8'd0;
  logic       enable = 1'b1;
  logic       length_status;
  logic [3:0] wave;
  logic [3:0] volume;
  int cmp_count = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  pulse_channel_gen dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .apu_clk(apu_clk),
    .half_frame(half_frame), .quarter_frame(quarter_frame), .op(op),
    .wdata(wdata), .enable(enable), .length_status(length_status),
    .wave(wave), .volume(volume)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    cmp_count++;
    assert (got === exp) else begin
      fail_count++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [7:0] d);
    op = 4'(1 << idx);
    wdata = d;
    step();
    op = 4'd0;
    wdata = 8'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic apu_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      apu_clk = 1'b1; step(); apu_clk = 1'b0;
    end
  endtask

  task automatic half_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      half_frame = 1'b1; step(); half_frame = 1'b0;
    end
  endtask

  task automatic quarter_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      quarter_frame = 1'b1; step(); quarter_frame = 1'b0;
    end
  endtask

  initial begin
    int seq_exp;
    int dec_exp;
    step();
    do_reset();
    check("reset_len", 16'(length_status), 16'd0);
    check("reset_wave", 16'(wave), 16'd0);
    check("reset_vol", 16'(volume), 16'd0);

    // Tone: duty 2, halt, constant volume 15, period 0x010.
    wr(0, 8'hBF); wr(2, 8'h10); wr(3, 8'h08);
    check("tone_vol", 16'(volume), 16'd15);
    check("tone_step0", 16'(wave), 16'd0);
    check("tone_len", 16'(length_status), 16'd1);
    for (int n = 1; n <= 137; n++) begin
      apu_ticks(1);
      seq_exp = ((n - 1) / 17 + 1) % 8;
      check($sformatf("tone_wave_t%0d", n), 16'(wave),
            (seq_exp >= 1 && seq_exp <= 4) ? 16'd15 : 16'd0);
    end
    apu_ticks(20);
    check("midtone_wave", 16'(wave), 16'd15);
    do_reset();
    check("midreset_wave", 16'(wave), 16'd0);
    check("midreset_vol", 16'(volume), 16'd0);
    check("midreset_len", 16'(length_status), 16'd0);
    check("midreset_seq", 16'(dut.seq_step_reg), 16'd0);

    // cpu_en low: writes and ticks ignored.
    wr(0, 8'hBF); wr(2, 8'h10); wr(3, 8'h08);
    cpu_en = 1'b0;
    wr(0, 8'h10);
    apu_ticks(1);
    cpu_en = 1'b1;
    check("cpu_en_vol", 16'(volume), 16'd15);
    check("cpu_en_wave", 16'(wave), 16'd0);

    // Length counter.
    half_ticks(300);
    check("halt_len", 16'(length_status), 16'd1);
    wr(0, 8'h9F); wr(3, 8'h08);
    half_ticks(253);
    check("len254_before", 16'(length_status), 16'd1);
    half_ticks(1);
    check("len254_after", 16'(length_status), 16'd0);
    check("len254_vol", 16'(volume), 16'd0);
    wr(3, 8'h00);
    half_ticks(9);
    check("len10_before", 16'(length_status), 16'd1);
    half_ticks(1);
    check("len10_after", 16'(length_status), 16'd0);
    wr(3, 8'hF8);
    half_ticks(29);
    check("len30_before", 16'(length_status), 16'd1);
    half_ticks(1);
    check("len30_after", 16'(length_status), 16'd0);
    op = 4'b1000; wdata = 8'h00; half_frame = 1'b1;
    step();
    op = 4'd0; half_frame = 1'b0;
    half_ticks(9);
    check("loadwins_before", 16'(length_status), 16'd1);
    half_ticks(1);
    check("loadwins_after", 16'(length_status), 16'd0);
    wr(3, 8'h08);
    check("enable_loaded", 16'(length_status), 16'd1);
    enable = 1'b0;
    step();
    check("enable_clear", 16'(length_status), 16'd0);
    wr(3, 8'h08);
    check("enable_blocks_load", 16'(length_status), 16'd0);
    enable = 1'b1;

    // Mute boundary on small periods.
    wr(0, 8'h1F); wr(3, 8'h08); wr(2, 8'h07);
    check("per7_mute", 16'(volume), 16'd0);
    wr(2, 8'h08);
    check("per8_unmuted", 16'(volume), 16'd15);

    // Envelope decay, hold, loop and constant volume.
    do_reset();
    wr(0, 8'h05); wr(2, 8'h10); wr(3, 8'h08);
    check("env_prestart", 16'(volume), 16'd0);
    for (int q = 1; q <= 100; q++) begin
      quarter_ticks(1);
      dec_exp = 15 - (q - 1) / 6;
      if (dec_exp < 0) dec_exp = 0;
      check($sformatf("env_q%0d", q), 16'(volume), 16'(dec_exp));
    end
    wr(0, 8'h25);
    quarter_ticks(2);
    check("env_loop_pre", 16'(volume), 16'd0);
    quarter_ticks(1);
    check("env_loop_wrap", 16'(volume), 16'd15);
    wr(0, 8'h15);
    check("env_const", 16'(volume), 16'd5);

`ifdef PULSE_SWEEP_EN
    do_reset();
    wr(0, 8'h1F); wr(2, 8'h00); wr(3, 8'h09);
    check("sweep_per_init", 16'(dut.period_reg), 16'h100);
    wr(1, 8'h81);
    half_ticks(1);
    check("sweep_add", 16'(dut.period_reg), 16'h180);
    do_reset();
    wr(0, 8'h1F); wr(2, 8'h00); wr(3, 8'h09); wr(1, 8'h89);
    half_ticks(1);
    check("sweep_neg", 16'(dut.period_reg), 16'h080);
    do_reset();
    wr(0, 8'h1F); wr(2, 8'h00); wr(3, 8'h0E); wr(1, 8'h81);
    check("sweep_ovf_mute", 16'(volume), 16'd0);
    half_ticks(1);
    check("sweep_ovf_hold", 16'(dut.period_reg), 16'h600);
    do_reset();
    wr(0, 8'h1F); wr(2, 8'h07); wr(3, 8'h08); wr(1, 8'h89);
    check("sweep_per7_neg", 16'(volume), 16'd0);
    wr(1, 8'h00);
    check("sweep_per7_off", 16'(volume), 16'd0);
`else
    do_reset();
    wr(0, 8'h1F); wr(2, 8'h00); wr(3, 8'h0E); wr(1, 8'h81);
    check("nosweep_vol", 16'(volume), 16'd15);
    half_ticks(1);
    check("nosweep_period", 16'(dut.period_reg), 16'h600);
    check("nosweep_vol_after", 16'(volume), 16'd15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end
endmodule
